key_expand_128: RTL
===================

KEY_EXPAND_128 -- requirements
Module: key_expand_128

Interface
REQ-001 SHALL have no parameters; AES-128 only (Nk=4, Nr=10).
REQ-002 clk  in  1  rising-edge clock; sole clock domain.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 start  in  1  request expansion of key_in; sampled only in IDLE.
REQ-005 key_in  in  128  cipher key, byte 0 = bits [127:120]; sampled on accepted start.
REQ-006 rk_ready  in  1  consumer accepts rk_out this cycle.
REQ-007 rk_valid  out  1  rk_out/rk_idx hold a valid round key.
REQ-008 rk_idx  out  4  round index 0..10 of rk_out.
REQ-009 rk_out  out  128  round key, word w[4i] in bits [127:96].
REQ-010 busy  out  1  high from accepted start until the round-10 key transfers.
REQ-011 err  out  1  sticky protocol-error flag (REQ-030).

Function
REQ-012 SHALL implement FSM states IDLE and RUN.
REQ-013 IDLE: start=1 -> load key_in into the key register, rk_idx=0, rcon=8'h01, go to RUN; start=0 -> stay.
REQ-014 RUN: rk_valid SHALL be 1 in every cycle; the first rk_valid is the cycle after start is accepted (latency 1).
REQ-015 Transfer occurs when rk_valid & rk_ready are both 1 on a rising edge.
REQ-016 Without a transfer, rk_out, rk_idx and rcon SHALL hold stable (no key advance).
REQ-017 On transfer with rk_idx<10: register <= next round key, rk_idx <= rk_idx+1, rcon <= xtime(rcon).
REQ-018 On transfer with rk_idx=10: go to IDLE, rk_valid <= 0, busy <= 0; key register and rk_idx hold their values.
REQ-019 Next key: t = SubWord(RotWord(w3)) xor {rcon,24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; computed in one cycle.
REQ-020 SubWord SHALL use four instances of the team's existing S-box lookup module, one per byte of RotWord(w3).
REQ-021 xtime: rcon<<1, xor 8'h1b if rcon[7] was 1; sequence 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-022 start while in RUN SHALL be ignored for expansion (expansion continues unaffected).
REQ-023 start in the same cycle as the round-10 transfer SHALL be ignored; a new start is accepted from IDLE in the following cycle at the earliest.
REQ-024 rk_ready while rk_valid=0 SHALL have no effect.
REQ-025 busy SHALL equal (state==RUN).

Reset
REQ-026 rst=1 on a rising edge SHALL force IDLE, rk_valid=0, busy=0, rk_idx=0, rk_out=128'h0, rcon=8'h01, err=0, overriding all other inputs.
REQ-027 rst asserted mid-expansion SHALL abort it; no further rk_valid until a new start.
REQ-028 start together with rst SHALL be ignored.

Configuration
REQ-029 Macro KEY_EXPAND_ERR_EN SHALL gate protocol-error detection.
REQ-030 Defined: err sets to 1 the cycle after any start=1 sampled in RUN and remains set until rst; expansion is unaffected.
REQ-031 Undefined: err SHALL be constant 0 and no detection logic is built; all other behaviour is identical.

Verification
REQ-032 key_in=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle, rk_ready=1 -> 11 consecutive rk_valid cycles; idx0=key_in, idx1=a0fafe1788542cb123a339392a6c7605, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6; busy low the cycle after idx10.
REQ-033 key_in=128'h0, rk_ready=1 -> idx1=62636363626363636263636362636363, idx10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-034 REQ-032 key, rk_ready toggling 1/0 each cycle -> same 11 keys in order, rk_out stable during every rk_ready=0 cycle, no skipped or repeated idx.
REQ-035 rst asserted while rk_idx=5 -> next cycle rk_valid=0, busy=0, rk_out=0; new start with REQ-033 key -> full correct sequence from idx0.
REQ-036 KEY_EXPAND_ERR_EN defined, start pulsed at rk_idx=3 -> err=1 next cycle and stays 1, key sequence unchanged; macro undefined, same stimulus -> err=0 throughout.

Source files
------------

// File: rtl/key_expand_128.sv
// AES-128 key expansion: streams round keys 0..10 over a valid/ready handshake, one round per transfer.
// Optional KEY_EXPAND_ERR_EN adds a sticky err flag for start pulses seen while running.
//
// state | meaning
// IDLE  | waiting for start; rk_valid and busy low
// RUN   | presenting round key rk_idx; advances on each transfer, returns to IDLE after round 10

module aes_sbox (
   input  logic [7:0] byte_val,
   output logic [7:0] sub_val
);

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the most significant byte of the table.
   logic [10:0] bit_pos;
   assign bit_pos = 11'd2047 - {byte_val, 3'b000};
   assign sub_val = SBOX_TABLE[bit_pos -: 8];

endmodule

module key_expand_128 (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   output logic         rk_valid,
   output logic [3:0]   rk_idx,
   output logic [127:0] rk_out,
   output logic         busy,
   output logic         err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state, state_nxt;
   logic [127:0] key_reg, key_nxt;
   logic [3:0]   idx_reg, idx_nxt;
   logic [7:0]   rcon, rcon_nxt;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot_w3, sub_w3, t_word;
   logic [31:0]  n0, n1, n2, n3;
   logic [7:0]   rcon_xtime;
   logic         xfer;

   assign w0 = key_reg[127:96];
   assign w1 = key_reg[95:64];
   assign w2 = key_reg[63:32];
   assign w3 = key_reg[31:0];

   assign rot_w3 = {w3[23:0], w3[31:24]};

   aes_sbox u_sbox_0 (.byte_val(rot_w3[31:24]), .sub_val(sub_w3[31:24]));
   aes_sbox u_sbox_1 (.byte_val(rot_w3[23:16]), .sub_val(sub_w3[23:16]));
   aes_sbox u_sbox_2 (.byte_val(rot_w3[15:8]),  .sub_val(sub_w3[15:8]));
   aes_sbox u_sbox_3 (.byte_val(rot_w3[7:0]),   .sub_val(sub_w3[7:0]));

   assign t_word = sub_w3 ^ {rcon, 24'h000000};
   assign n0 = w0 ^ t_word;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign rcon_xtime = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

   assign xfer = (state == RUN) && rk_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         key_reg <= '0;
         idx_reg <= '0;
         rcon    <= 8'h01;
      end else begin
         state   <= state_nxt;
         key_reg <= key_nxt;
         idx_reg <= idx_nxt;
         rcon    <= rcon_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      key_nxt   = key_reg;
      idx_nxt   = idx_reg;
      rcon_nxt  = rcon;
      case (state)
         IDLE: begin
            if (start) begin
               key_nxt   = key_in;
               idx_nxt   = 4'd0;
               rcon_nxt  = 8'h01;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (xfer) begin
               // Round 10 leaves key and index on display so the last key remains observable.
               if (idx_reg == 4'd10) begin
                  state_nxt = IDLE;
               end else begin
                  key_nxt  = {n0, n1, n2, n3};
                  idx_nxt  = idx_reg + 4'd1;
                  rcon_nxt = rcon_xtime;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rk_valid = (state == RUN);
   assign busy     = (state == RUN);
   assign rk_out   = key_reg;
   assign rk_idx   = idx_reg;

`ifdef KEY_EXPAND_ERR_EN
   logic err_reg;

   always_ff @(posedge clk) begin
      if (rst)
         err_reg <= 1'b0;
      else if ((state == RUN) && start)
         err_reg <= 1'b1;
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule
